// File: rtl/i2c_master.sv
// Single-byte I2C master: one random write, or one random read (dummy write, repeated START, read) per command.
// Define I2C_MASTER_ACK_CHECK_EN to abort to STOP on a slave NACK and report it on ack_err.
module i2c_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_id,
  input  logic [7:0] word_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND, RACK, RESTART, RECV, MNACK, STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             scl_q, scl_d;
  logic             sda_lo_q, sda_lo_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdat_q, wdat_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_q, rx_d;

  logic             qtr_end, slot_end, samp, sda_in, ack_abort;

  assign sda_in   = sda;
  assign qtr_end  = (div_q == DIV_W'(CLK_DIV - 1));
  assign slot_end = qtr_end && (qtr_q == 2'd3);
  assign samp     = qtr_end && (qtr_q == 2'd2);

`ifdef I2C_MASTER_ACK_CHECK_EN
  logic nack_q, nack_d;
  assign ack_abort = nack_q;
`else
  assign ack_abort = 1'b0;
`endif

  // Bus levels for a given state and quarter: {scl, sda_lo}; sda_lo=1 pulls SDA low.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                           input logic msb);
    logic hi;
    hi = q[1];
    case (st)
      IDLE:    bus_drive = 2'b10;
      START:   bus_drive = {1'b1, hi};
      SEND:    bus_drive = {hi, ~msb};
      RESTART: bus_drive = {hi, q == 2'd3};
      STOP:    bus_drive = {hi, q != 2'd3};
      default: bus_drive = {hi, 1'b0};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = qtr_end ? '0 : div_q + DIV_W'(1);
    qtr_d     = qtr_end ? qtr_q + 2'd1 : qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
`ifdef I2C_MASTER_ACK_CHECK_EN
    nack_d    = nack_q;
    if (state_q == RACK && samp) nack_d = sda_in;
`endif

    if (state_q == IDLE) begin
      div_d = '0;
      qtr_d = 2'd0;
      if (start) begin
        rw_d      = rw;
        dev_d     = dev_id;
        addr_d    = word_addr;
        wdat_d    = wr_data;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        byte_d    = 2'd0;
        state_d   = START;
      end
    end else begin
      if (state_q == RECV && samp) rx_d = {rx_q[6:0], sda_in};
      if (slot_end) begin
        case (state_q)
          START: begin
            state_d = SEND;
            shreg_d = {dev_q, 1'b0};
            bit_d   = 3'd0;
          end
          SEND: begin
            if (bit_q == 3'd7) begin
              state_d = RACK;
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
          RACK: begin
            bit_d = 3'd0;
            if (ack_abort) begin
              ack_err_d = 1'b1;
              state_d   = STOP;
            end else begin
              // byte_q names the byte just acknowledged
              case (byte_q)
                2'd0: begin
                  state_d = SEND;
                  shreg_d = addr_q;
                  byte_d  = 2'd1;
                end
                2'd1: begin
                  byte_d  = 2'd2;
                  state_d = rw_q ? RESTART : SEND;
                  shreg_d = wdat_q;
                end
                2'd2: begin
                  byte_d  = 2'd3;
                  state_d = rw_q ? RECV : STOP;
                end
                default: state_d = STOP;
              endcase
            end
          end
          RESTART: begin
            state_d = SEND;
            shreg_d = {dev_q, 1'b1};
            bit_d   = 3'd0;
          end
          RECV: begin
            if (bit_q == 3'd7) state_d = MNACK;
            else               bit_d   = bit_q + 3'd1;
          end
          MNACK: begin
            rd_data_d = rx_q;
            state_d   = STOP;
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    {scl_d, sda_lo_d} = bus_drive(state_d, qtr_d, shreg_d[7]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_lo_q  <= 1'b0;
      rd_data_q <= 8'h00;
`ifdef I2C_MASTER_ACK_CHECK_EN
      nack_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_lo_q  <= sda_lo_d;
      rd_data_q <= rd_data_d;
`ifdef I2C_MASTER_ACK_CHECK_EN
      nack_q    <= nack_d;
`endif
    end
  end

  // Operand and shift registers carry no reset; they are loaded before use.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    dev_q   <= dev_d;
    addr_q  <= addr_d;
    wdat_q  <= wdat_d;
    shreg_q <= shreg_d;
    rx_q    <= rx_d;
  end

  assign sda     = sda_lo_q ? 1'b0 : 1'bz;
  assign scl     = scl_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master with a behavioural I2C memory slave (id 7'b1000000) on a pulled-up SDA.
`timescale 1ns/1ps
module tb_i2c_master;

  localparam int CD = 4;
  localparam logic [6:0] SLV_ID = 7'b1000000;
  localparam int LAT_W = 1 + 29 * 4 * CD;
  localparam int LAT_R = 1 + 39 * 4 * CD;
`ifdef I2C_MASTER_ACK_CHECK_EN
  localparam int LAT_BAD = 1 + 11 * 4 * CD;
  localparam logic AE_BAD = 1'b1;
`else
  localparam int LAT_BAD = LAT_W;
  localparam logic AE_BAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_id = 7'h00;
  logic [7:0] word_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       busy, done, ack_err, scl;
  wire        sda_w;
  logic       slave_oe = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_oe ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .dev_id(dev_id),
    .word_addr(word_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .done(done), .ack_err(ack_err), .scl(scl), .sda(sda_w)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- slave memory model ----------------
  typedef enum {S_IDLE, S_DEV, S_ADDR, S_WDATA, S_READ} sph_t;
  sph_t       ph = S_IDLE;
  sph_t       nxt = S_IDLE;
  int         bitc = 0;
  logic [7:0] sh = 8'h00, tx = 8'h00, ptr = 8'h00;
  logic [7:0] mem [256];
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       mnack_seen = 1'b0;
  logic       drv_val = 1'b0, drv_tgl = 1'b0, drv_hold = 1'b0;

  always @(drv_tgl) begin
    drv_hold = drv_val;
    #72;
    slave_oe = drv_hold;
  end

  task automatic sched(input logic v);
    drv_val = v;
    drv_tgl = ~drv_tgl;
  endtask

  always @(scl or sda_w) begin
    #1;
    if (scl !== scl_p) begin
      if (scl === 1'b1) begin
        case (ph)
          S_DEV, S_ADDR, S_WDATA:
            if (bitc < 8) begin sh = {sh[6:0], sda_w}; bitc++; end
          S_READ:
            if (bitc == 9) begin
              if (sda_w === 1'b1) mnack_seen = 1'b1;
              ptr = ptr + 8'd1;
              ph = S_IDLE;
            end
          default: ;
        endcase
      end else begin
        case (ph)
          S_DEV, S_ADDR, S_WDATA: begin
            if (bitc == 8) begin
              bitc = 9;
              if (ph == S_DEV) begin
                if (sh[7:1] == SLV_ID) begin nxt = sh[0] ? S_READ : S_ADDR; sched(1'b1); end
                else begin ph = S_IDLE; bitc = 0; end
              end else if (ph == S_ADDR) begin
                ptr = sh; nxt = S_WDATA; sched(1'b1);
              end else begin
                mem[ptr] = sh; ptr = ptr + 8'd1; nxt = S_WDATA; sched(1'b1);
              end
            end else if (bitc == 9) begin
              ph = nxt; bitc = 0;
              if (ph == S_READ) begin tx = mem[ptr]; sched(~tx[7]); bitc = 1; end
              else sched(1'b0);
            end
          end
          S_READ: begin
            if (bitc < 8) begin sched(~tx[7-bitc]); bitc++; end
            else if (bitc == 8) begin sched(1'b0); bitc = 9; end
          end
          default: ;
        endcase
      end
    end else if (sda_w !== sda_p && scl === 1'b1) begin
      if (sda_w === 1'b0) begin ph = S_DEV; bitc = 0; end
      else ph = S_IDLE;
    end
    scl_p = scl;
    sda_p = sda_w;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] rd;
    logic       ae;
    int         lat;
    int         st;
    string      nm;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending command", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_rd_data"}, 32'(rd_data), 32'(e.rd));
        check({e.nm, "_ack_err"}, 32'(ack_err), 32'(e.ae));
        check({e.nm, "_latency"}, 32'(cyc - e.st + 1), 32'(e.lat));
        check({e.nm, "_busy_low"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] a,
                       input logic [7:0] w, input logic push, input logic [7:0] erd,
                       input logic eae, input int elat, input string nm);
    exp_t e;
    @(negedge clk);
    start = 1'b1; rw = r; dev_id = d; word_addr = a; wr_data = w;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.rd = erd; e.ae = eae; e.lat = elat; e.st = cyc; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    int c0;
    int k;
    c0 = done_cnt;
    k = 0;
    while (done_cnt == c0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == c0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected one", nm, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda_w), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    issue(1'b0, SLV_ID, 8'h10, 8'h5A, 1'b1, 8'h00, 1'b0, LAT_W, "wr_5a");
    check("wr_busy_next_cycle", 32'(busy), 32'd1);
    wait_done(1000, "wr_5a");
    check("mem_10_after_wr", 32'(mem[8'h10]), 32'h5A);

    mnack_seen = 1'b0;
    issue(1'b1, SLV_ID, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0, LAT_R, "rd_10");
    wait_done(1000, "rd_10");
    check("rd_10_master_nack", 32'(mnack_seen), 32'd1);

    mnack_seen = 1'b0;
    issue(1'b1, SLV_ID, 8'h00, 8'h00, 1'b1, 8'h03, 1'b0, LAT_R, "rd_00");
    wait_done(1000, "rd_00");
    check("rd_00_master_nack", 32'(mnack_seen), 32'd1);

    issue(1'b1, SLV_ID, 8'h05, 8'h00, 1'b1, 8'h26, 1'b0, LAT_R, "rd_05");
    wait_done(1000, "rd_05");

    issue(1'b0, 7'h21, 8'h10, 8'h77, 1'b1, 8'h26, AE_BAD, LAT_BAD, "wr_baddev");
    wait_done(1000, "wr_baddev");
    check("mem_10_unchanged", 32'(mem[8'h10]), 32'h5A);

    dc = done_cnt;
    issue(1'b0, SLV_ID, 8'h30, 8'hC3, 1'b1, 8'h26, 1'b0, LAT_W, "wr_busy_start");
    repeat (100) @(posedge clk);
    @(negedge clk);
    start = 1'b1; rw = 1'b1; dev_id = 7'h11; word_addr = 8'h99; wr_data = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done(1000, "wr_busy_start");
    repeat (700) @(posedge clk);
    #1;
    check("busy_start_one_done", 32'(done_cnt - dc), 32'd1);
    check("mem_30_written", 32'(mem[8'h30]), 32'hC3);
    check("mem_99_untouched", 32'(mem[8'h99]), 32'h32);

    issue(1'b0, SLV_ID, 8'h20, 8'h44, 1'b0, 8'h00, 1'b0, 0, "wr_abort");
    repeat (196) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_sda", 32'(sda_w), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_data", 32'(rd_data), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    issue(1'b0, SLV_ID, 8'h20, 8'h33, 1'b1, 8'h00, 1'b0, LAT_W, "wr_33");
    wait_done(1000, "wr_33");
    check("mem_20_after_wr", 32'(mem[8'h20]), 32'h33);

    issue(1'b1, SLV_ID, 8'h20, 8'h00, 1'b1, 8'h33, 1'b0, LAT_R, "rd_20");
    wait_done(1000, "rd_20");

    repeat (10) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
